// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio job sequencer.
package audio_pkg;

    localparam int DEFAULT_WORDS      = 64;
    localparam int DEFAULT_INPUT_SIZE = 512;
    localparam int SEMI_W             = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } seq_state_t;

    // Index width for a frame of n words; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_counter.sv
// Modulo-WORDS word counter: advances on inc, wraps to 0 after WORDS-1, flags the wrap.
module handshake_counter
    import audio_pkg::*;
#(
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        inc,
    input  logic                        clr,
    output logic [idx_width(WORDS)-1:0] count,
    output logic                        wrap
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + IDX_W'(1);
        end
    end

endmodule

// File: rtl/audio_job_sequencer.sv
// Runs one pitch-shift job: configure, load a frame, start, wait, drain, report done.
// Optional WAIT timeout enabled by defining AUDIO_SEQ_TIMEOUT_EN.
module audio_job_sequencer
    import audio_pkg::*;
#(
    parameter int INPUT_SIZE     = DEFAULT_INPUT_SIZE,
    parameter int WORDS          = DEFAULT_WORDS,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_req,
    input  logic [SEMI_W-1:0]           semitones,
    output logic                        job_busy,
    output logic                        job_done,
    output logic                        job_err,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [INPUT_SIZE-1:0]       rd_data,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [INPUT_SIZE-1:0]       wr_data,
    output logic                        ap_data_wr_en,
    output logic [idx_width(WORDS)-1:0] ap_input_index,
    output logic [INPUT_SIZE-1:0]       ap_data_in,
    output logic                        ap_pitch_wr_en,
    output logic [SEMI_W-1:0]           ap_semitones,
    output logic                        ap_start,
    output logic [idx_width(WORDS)-1:0] ap_output_index,
    input  logic                        ap_done,
    input  logic [INPUT_SIZE-1:0]       ap_data_out,
    output seq_state_t                  fsm_state
);

    // Both streams use valid/ready: a word moves on a clock edge where valid and
    // ready are both high; the sender holds data stable while ready is low.

    localparam int IDX_W = idx_width(WORDS);

    seq_state_t        state, next_state;
    logic [SEMI_W-1:0] semi_q;
    logic [IDX_W-1:0]  load_count, drain_count;
    logic              load_inc, load_wrap, drain_inc, drain_wrap, cnt_clr;
    logic              timeout;

    assign load_inc  = (state == LOAD) && rd_valid;
    assign drain_inc = (state == DRAIN) && wr_ready;
    assign cnt_clr   = (state == IDLE);

    handshake_counter #(.WORDS(WORDS)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_inc),
        .clr   (cnt_clr),
        .count (load_count),
        .wrap  (load_wrap)
    );

    handshake_counter #(.WORDS(WORDS)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drain_inc),
        .clr   (cnt_clr),
        .count (drain_count),
        .wrap  (drain_wrap)
    );

`ifdef AUDIO_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a simultaneous ap_done still wins.
    assign timeout = (state == WAIT) && !ap_done && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign job_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE && job_req) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign job_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            semi_q <= '0;
        end else if (state == IDLE && job_req) begin
            semi_q <= semitones;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (job_req) next_state = CONFIG;
            CONFIG:  next_state = LOAD;
            LOAD:    if (load_wrap) next_state = START;
            START:   next_state = WAIT;
            WAIT: begin
                if (ap_done)      next_state = DRAIN;
                else if (timeout) next_state = DONE;
            end
            DRAIN:   if (drain_wrap) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        job_busy        = (state != IDLE);
        job_done        = 1'b0;
        rd_ready        = 1'b0;
        wr_valid        = 1'b0;
        wr_data         = '0;
        ap_data_wr_en   = 1'b0;
        ap_input_index  = '0;
        ap_data_in      = '0;
        ap_pitch_wr_en  = 1'b0;
        ap_semitones    = '0;
        ap_start        = 1'b0;
        ap_output_index = '0;
        fsm_state       = state;
        case (state)
            CONFIG: begin
                ap_pitch_wr_en = 1'b1;
                ap_semitones   = semi_q;
            end
            LOAD: begin
                rd_ready       = 1'b1;
                ap_data_wr_en  = load_inc;
                ap_input_index = load_count;
                ap_data_in     = load_inc ? rd_data : '0;
            end
            START: ap_start = 1'b1;
            DRAIN: begin
                wr_valid        = 1'b1;
                wr_data         = ap_data_out;
                ap_output_index = drain_count;
            end
            DONE:  job_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_audio_job_sequencer.sv
// Bench for audio_job_sequencer: job table, stream drivers, processor stand-in and scoreboard.
`timescale 1ns/1ps
module tb_audio_job_sequencer;
    import audio_pkg::*;

    localparam int IS = 32;
    localparam int W  = 64;
    localparam int TO = 32;
    localparam int IW = $clog2(W);

`ifdef AUDIO_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, job_req, job_busy, job_done, job_err;
    logic [4:0]    semitones, ap_semitones;
    logic          rd_valid, rd_ready, wr_valid, wr_ready;
    logic [IS-1:0] rd_data, wr_data, ap_data_in, ap_data_out;
    logic          ap_data_wr_en, ap_pitch_wr_en, ap_start, ap_done;
    logic [IW-1:0] ap_input_index, ap_output_index;
    seq_state_t    fsm_state;

    audio_job_sequencer #(.INPUT_SIZE(IS), .WORDS(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .job_req(job_req), .semitones(semitones),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .ap_data_wr_en(ap_data_wr_en), .ap_input_index(ap_input_index), .ap_data_in(ap_data_in),
        .ap_pitch_wr_en(ap_pitch_wr_en), .ap_semitones(ap_semitones), .ap_start(ap_start),
        .ap_output_index(ap_output_index), .ap_done(ap_done), .ap_data_out(ap_data_out),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Processor stand-in: output word = input word + pitch shift (mod 2^IS).
    logic [IS-1:0] in_mem [W];
    logic [IS-1:0] out_mem [W];
    logic [4:0]    pitch_reg = '0;
    assign ap_data_out = out_mem[ap_output_index];

    initial for (int i = 0; i < W; i++) out_mem[i] = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ap_data_wr_en) in_mem[ap_input_index] = ap_data_in;
            if (ap_pitch_wr_en) pitch_reg = ap_semitones;
            if (ap_start) for (int i = 0; i < W; i++) out_mem[i] = in_mem[i] + IS'(pitch_reg);
        end
    end

    // Scoreboard state
    logic [IS-1:0] exp_q[$];
    logic [IS-1:0] exp_out_q[$];
    logic [IS-1:0] src_words [W];
    logic [4:0]    exp_semi;
    int  pitch_cnt, load_cnt, start_cnt, drain_cnt, done_cnt;
    int  start_cyc, last_acc_cyc, done_cyc;
    bit  in_job = 0, done_given, aborted;
    bit  prev_stall = 0;
    logic [IS-1:0] prev_data;
    logic [IW-1:0] prev_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_job = 0;
            prev_stall = 0;
        end else begin
            check("job_busy", job_busy, in_job);
            if (ap_pitch_wr_en) begin
                pitch_cnt++;
                check("ap_semitones", ap_semitones, exp_semi);
            end
            if (rd_ready && rd_valid) check("ap_data_wr_en", ap_data_wr_en, 1);
            if (ap_data_wr_en) begin
                check("wr_en_without_rd_valid", rd_valid, 1);
                check("ap_input_index", ap_input_index, load_cnt);
                if (exp_q.size() == 0) check("ap_data_wr_en_extra", ap_data_wr_en, 0);
                else check("ap_data_in", ap_data_in, exp_q.pop_front());
                load_cnt++;
            end
            if (ap_start) begin
                start_cnt++;
                start_cyc = cyc;
                check("words_before_start", load_cnt, W);
            end
            if (prev_stall) begin
                check("wr_valid_hold", wr_valid, 1);
                check("wr_data_hold", wr_data, prev_data);
                check("out_index_hold", ap_output_index, prev_idx);
            end
            if (wr_valid) begin
                check("wr_valid_after_ap_done", done_given, 1);
                if (wr_ready) begin
                    check("ap_output_index", ap_output_index, drain_cnt);
                    if (exp_out_q.size() == 0) check("wr_valid_extra", wr_valid, 0);
                    else check("wr_data", wr_data, exp_out_q.pop_front());
                    drain_cnt++;
                    last_acc_cyc = cyc;
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_data  = wr_data;
            prev_idx   = ap_output_index;
            if (job_done) begin
                done_cnt++;
                done_cyc = cyc;
                in_job = 0;
            end else if (!in_job && job_req) begin
                in_job = 1;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_job_busy"}, job_busy, 0);
        check({tag, "_job_done"}, job_done, 0);
        check({tag, "_job_err"}, job_err, 0);
        check({tag, "_rd_ready"}, rd_ready, 0);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_ap_data_wr_en"}, ap_data_wr_en, 0);
        check({tag, "_ap_input_index"}, ap_input_index, 0);
        check({tag, "_ap_data_in"}, ap_data_in, 0);
        check({tag, "_ap_pitch_wr_en"}, ap_pitch_wr_en, 0);
        check({tag, "_ap_semitones"}, ap_semitones, 0);
        check({tag, "_ap_start"}, ap_start, 0);
        check({tag, "_ap_output_index"}, ap_output_index, 0);
        check({tag, "_fsm_state"}, fsm_state, IDLE);
    endtask

    // Job table: stimulus knobs plus expected word/done counts for a run that is not timed out.
    typedef struct {
        logic [4:0] semi;
        int rd_mode;      // 0 back-to-back, 1 every other cycle, 2 random
        int wr_stall;     // low cycles per word, -1 random
        int done_delay;   // ap_done on this WAIT cycle (>=1)
        bit spurious;     // extra ap_done pulse during CONFIG
        bit noise;        // job_req pulses during LOAD and DONE
        int abort_at;     // reset when drain index reaches this, -1 none
        int exp_loads;
        int exp_drains;
        int exp_dones;
    } vec_t;

    vec_t cur;
    int src_i, src_g, snk_c, snk_g, dn_g, nz_g, ab_g;
    bit src_acc, snk_acc, snk_stl;

    task automatic run_job(input vec_t v);
        bit exp_to;
        int g;
        cur = v;
        exp_to = TIMEOUT_EN && (v.abort_at < 0) && (v.done_delay > TO);
        pitch_cnt = 0; load_cnt = 0; start_cnt = 0; drain_cnt = 0; done_cnt = 0;
        done_given = 0; aborted = 0;
        start_cyc = -100; last_acc_cyc = -100; done_cyc = -100;
        exp_q.delete(); exp_out_q.delete();
        exp_semi = v.semi;
        for (int i = 0; i < W; i++) begin
            src_words[i] = IS'($urandom);
            exp_q.push_back(src_words[i]);
            exp_out_q.push_back(src_words[i] + IS'(v.semi));
        end

        @(posedge clk); #1;
        job_req = 1; semitones = v.semi;
        @(posedge clk); #1;
        job_req = 0; semitones = 5'($urandom);

        fork
            begin : source_driver
                src_i = 0; src_g = 0;
                while (src_i < W && src_g < 5000 && !aborted) begin
                    case (cur.rd_mode)
                        0: rd_valid = 1'b1;
                        1: rd_valid = (src_g % 2 == 0);
                        default: rd_valid = 1'($urandom_range(0, 1));
                    endcase
                    rd_data = src_words[src_i];
                    @(negedge clk); src_acc = rd_valid && rd_ready;
                    @(posedge clk); #1;
                    if (src_acc) src_i++;
                    src_g++;
                end
                rd_valid = 0;
            end
            begin : sink_driver
                snk_c = 0; snk_g = 0;
                while (drain_cnt < W && done_cnt == 0 && !aborted && snk_g < 20000) begin
                    if (cur.wr_stall < 0) wr_ready = 1'($urandom_range(0, 1));
                    else wr_ready = (snk_c >= cur.wr_stall);
                    @(negedge clk);
                    snk_acc = wr_valid && wr_ready;
                    snk_stl = wr_valid && !wr_ready;
                    @(posedge clk); #1;
                    if (snk_acc) snk_c = 0;
                    else if (snk_stl) snk_c++;
                    snk_g++;
                end
                wr_ready = 0;
            end
            begin : done_driver
                if (cur.spurious) begin
                    ap_done = 1;
                    @(posedge clk); #1;
                    ap_done = 0;
                end
                dn_g = 0;
                @(negedge clk);
                while (!ap_start && dn_g < 5000 && !aborted) begin
                    @(negedge clk); dn_g++;
                end
                if (ap_start) begin
                    repeat (cur.done_delay) @(posedge clk);
                    #1;
                    done_given = 1;
                    ap_done = 1;
                    @(posedge clk); #1;
                    ap_done = 0;
                end
            end
            begin : req_noise
                if (cur.noise) begin
                    nz_g = 0;
                    @(negedge clk);
                    while (!rd_ready && nz_g < 2000) begin @(negedge clk); nz_g++; end
                    @(posedge clk); #1;
                    job_req = 1;
                    @(posedge clk); #1;
                    job_req = 0;
                    nz_g = 0;
                    while (!job_done && nz_g < 20000 && !aborted) begin @(negedge clk); nz_g++; end
                    if (job_done) begin
                        job_req = 1;
                        @(posedge clk); #1;
                        job_req = 0;
                    end
                end
            end
            begin : mid_drain_reset
                if (cur.abort_at >= 0) begin
                    ab_g = 0;
                    while (!(wr_valid && ap_output_index == IW'(cur.abort_at)) && ab_g < 20000) begin
                        @(posedge clk); #1; ab_g++;
                    end
                    check("abort_index", ap_output_index, cur.abort_at);
                    rst_n = 0;
                    aborted = 1;
                    @(posedge clk); #1;
                    check_idle_outputs("mid_job_reset");
                    rst_n = 1;
                end
            end
        join

        g = 0;
        while (done_cnt == 0 && !aborted && g < 5000) begin @(posedge clk); g++; end
        repeat (5) @(posedge clk);
        #1;

        check("pitch_writes", pitch_cnt, 1);
        check("load_words", load_cnt, v.exp_loads);
        check("start_pulses", start_cnt, 1);
        check("drain_words", drain_cnt, exp_to ? 0 : v.exp_drains);
        check("job_done_pulses", done_cnt, v.exp_dones);
        check("job_err", job_err, exp_to);
        check("unwritten_words", exp_q.size(), 0);
        check("job_busy_after", job_busy, 0);
        if (exp_to) check("timeout_latency", done_cyc - start_cyc, TO + 1);
        else if (v.abort_at < 0) check("done_after_last_word", done_cyc, last_acc_cyc + 1);
    endtask

    vec_t vecs [9];

    initial begin
        rst_n = 0; job_req = 1; semitones = 5'h1f;
        rd_valid = 1; rd_data = IS'($urandom); wr_ready = 1; ap_done = 1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        job_req = 0; rd_valid = 0; ap_done = 0; wr_ready = 0;
        rst_n = 1;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        //          semi  rd wr  dly  sp nz abort  loads drains dones
        vecs[0] = '{5'd5,  0, 0,   3, 0, 0, -1,    W,    W,     1};
        vecs[1] = '{5'd12, 1, 0,   5, 0, 0, -1,    W,    W,     1};
        vecs[2] = '{5'd31, 0, 3, 100, 0, 0, -1,    W,    W,     1};
        vecs[3] = '{5'd0,  2, -1,  7, 1, 1, -1,    W,    W,     1};
        vecs[4] = '{5'd9,  0, 1,   4, 0, 0, 10,    W,    10,    0};
        vecs[5] = '{5'd17, 2, -1, 32, 0, 0, -1,    W,    W,     1};
        vecs[6] = '{5'd22, 1, -1, 33, 0, 0, -1,    W,    W,     1};
        vecs[7] = '{5'd3,  0, 0, 200, 0, 1, -1,    W,    W,     1};
        vecs[8] = '{5'($urandom), 2, -1, $urandom_range(1, 20), 1, 0, -1, W, W, 1};

        for (int r = 0; r < 9; r++) run_job(vecs[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: actual=%0d cycles required=finish earlier", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/audio_job_sequencer.md
AUDIO_JOB_SEQUENCER -- requirements
Module: audio_job_sequencer

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 512, meaning the width in bits of one transfer word.
REQ-002 SHALL have parameter WORDS, default 64, meaning the number of words per job frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16384, meaning the maximum number of WAIT cycles before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have ports job_req (in, 1, start pulse), semitones (in, 5, pitch shift) and job_busy (out, 1).
REQ-007 SHALL have ports job_done (out, 1, 1-cycle pulse) and job_err (out, 1, sticky timeout flag).
REQ-008 SHALL have ports rd_valid (in, 1), rd_ready (out, 1) and rd_data (in, INPUT_SIZE): the source stream.
REQ-009 SHALL have ports wr_valid (out, 1), wr_ready (in, 1) and wr_data (out, INPUT_SIZE): the sink stream.
REQ-010 SHALL have processor-side outputs ap_data_wr_en (1), ap_input_index (clog2 WORDS), ap_data_in (INPUT_SIZE), ap_pitch_wr_en (1), ap_semitones (5), ap_start (1) and ap_output_index (clog2 WORDS).
REQ-011 SHALL have processor-side inputs ap_done (1) and ap_data_out (INPUT_SIZE), where ap_data_out is a combinational read of ap_output_index.

Function
REQ-012 SHALL implement the states IDLE, CONFIG, LOAD, START, WAIT, DRAIN and DONE.
REQ-013 SHALL, in IDLE with job_req=1, latch semitones, clear job_err and go to CONFIG; job_req SHALL be ignored in every other state.
REQ-014 SHALL, in CONFIG, drive ap_pitch_wr_en=1 and ap_semitones=latched value for exactly one cycle, then go to LOAD.
REQ-015 SHALL, in LOAD, drive rd_ready=1; on rd_valid&rd_ready it SHALL drive ap_data_wr_en=1, ap_data_in=rd_data and ap_input_index=load count, then increment the count.
REQ-016 SHALL, in LOAD, stall with no write and no count change when rd_valid=0.
REQ-017 SHALL, when the load count wraps from WORDS-1 on an accepted word, reset the count and go to START.
REQ-018 SHALL, in START, pulse ap_start for exactly one cycle, then go to WAIT.
REQ-019 SHALL, in WAIT, go to DRAIN on ap_done=1; an ap_done seen in any other state SHALL be ignored.
REQ-020 SHALL, in DRAIN, drive wr_valid=1, wr_data=ap_data_out and ap_output_index=drain count; the index SHALL advance only on wr_valid&wr_ready.
REQ-021 SHALL hold wr_data and the index stable while wr_ready=0.
REQ-022 SHALL go to DONE when the last word (index WORDS-1) is accepted.
REQ-023 SHALL, in DONE, pulse job_done for one cycle, then go to IDLE.
REQ-024 SHALL drive job_busy=1 in every state except IDLE.
REQ-025 SHALL keep every ap_* strobe and the rd_ready/wr_valid handshakes at 0 outside the states named above.
REQ-026 SHALL, on job_req in the same cycle that DONE returns to IDLE, ignore it; a new job SHALL be accepted no earlier than the next cycle in IDLE.

Reset
REQ-027 SHALL, on clk edge with rst_n=0, set state=IDLE and clear all counters and the latched semitones.
REQ-028 SHALL, on reset, drive every output to 0.
REQ-029 SHALL, on reset mid-job (any state), abort with no job_done pulse, clear job_err and produce no further ap_* strobes.

Configuration
REQ-030 SHALL, with macro AUDIO_SEQ_TIMEOUT_EN defined, count WAIT cycles and, when the count reaches TIMEOUT_CYCLES, set job_err=1 and pulse job_done, going DONE to IDLE without entering DRAIN.
REQ-031 SHALL, without AUDIO_SEQ_TIMEOUT_EN, wait in WAIT indefinitely, tie job_err to 0 and omit the timeout counter.

Structure
REQ-032 SHALL declare the state enum and default WORDS/INPUT_SIZE localparams in shared package audio_pkg.
REQ-033 SHALL place one sub-module, handshake_counter (modulo-WORDS counter with inc/clr/wrap outputs), instantiated twice, for load and drain.

Verification
REQ-034 SHALL verify that job_req with semitones=5, with 64 back-to-back rd_valid words, gives one ap_pitch_wr_en with ap_semitones=5, 64 writes at indices 0..63, then one ap_start.
REQ-035 SHALL verify that rd_valid toggled every other cycle gives exactly 64 writes with no duplicated or skipped index.
REQ-036 SHALL verify that ap_done after 100 cycles with wr_ready held low 3 cycles per word gives 64 words in index order, wr_data stable while stalled, and job_done one cycle after the last word.
REQ-037 SHALL verify that, with AUDIO_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=32, no ap_done gives job_err=1 and job_done after 32 WAIT cycles, with no wr_valid.
REQ-038 SHALL verify that rst_n low during DRAIN word 10 gives IDLE next cycle, all outputs 0 and no job_done, and that a fresh job afterwards completes normally.
REQ-039 SHALL verify that job_req pulsed during LOAD and during the DONE cycle is ignored, giving exactly one job_done.
